// File: rtl/tpu_fp_pkg.sv
// Floating-point types and constants shared by the PE datapath and the output requantizer.
package tpu_fp_pkg;

  localparam int FP8_BIAS  = 7;
  localparam int BF16_BIAS = 127;

  localparam logic [7:0] FP8_MAX_POS = 8'h7E;
  localparam logic [7:0] FP8_NAN     = 8'h7F;

  typedef struct packed {
    logic       s;
    logic [7:0] e;
    logic [6:0] m;
  } bf16_t;

  typedef struct packed {
    logic       s;
    logic [3:0] e;
    logic [2:0] m;
  } fp8_t;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_e;

endpackage

// File: rtl/bf16_to_fp8.sv
// Combinational BF16 -> FP8 E4M3 encoder: round-to-nearest-even, flush-to-zero, saturate.
module bf16_to_fp8
  import tpu_fp_pkg::*;
(
  input  logic [15:0] bf16,
  output logic [7:0]  fp8,
  output logic        sat
);

  localparam logic signed [9:0] EXP_OFS = 10'(BF16_BIAS - FP8_BIAS);

  bf16_t              x;
  logic               rnd;
  logic [3:0]         mant;
  logic signed [9:0]  f;
  logic signed [9:0]  f_r;
  logic [2:0]         m_r;

  assign x = bf16;

  always_comb begin
    rnd  = x.m[3] && ((|x.m[2:0]) || x.m[4]);
    mant = {1'b0, x.m[6:4]} + {3'b000, rnd};
    f    = $signed({2'b00, x.e}) - EXP_OFS;
    // Rounding 1.111 up carries into the exponent.
    f_r  = mant[3] ? f + 10'sd1 : f;
    m_r  = mant[3] ? 3'b000 : mant[2:0];

    fp8 = 8'h00;
    sat = 1'b0;
    if (x.e == 8'h00) begin
      fp8 = {x.s, 7'h00};
    end else if (x.e == 8'hFF) begin
      sat = 1'b1;
      fp8 = (x.m != 7'h00) ? FP8_NAN : {x.s, FP8_MAX_POS[6:0]};
    end else if (f_r < 10'sd1) begin
      fp8 = {x.s, 7'h00};
    end else if (f_r > 10'sd15 || (f_r == 10'sd15 && m_r == 3'b111)) begin
      // E=15,M=7 is the E4M3 NaN code, so clamp to the largest finite value.
      sat = 1'b1;
      fp8 = {x.s, FP8_MAX_POS[6:0]};
    end else begin
      fp8 = {x.s, f_r[3:0], m_r};
    end
  end

endmodule

// File: rtl/bf16_fp8_drain.sv
// Captures one BF16 row from the array and streams it out as FP8 E4M3 bytes on valid/ready.
module bf16_fp8_drain
  import tpu_fp_pkg::*;
#(
  parameter int  N_COLS = 4,
  parameter int  CNT_W  = 16,
  localparam int IDX_W  = (N_COLS > 1) ? $clog2(N_COLS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [16*N_COLS-1:0] load_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_data,
  output logic [IDX_W-1:0]     out_idx,
  output logic                 out_last,
  output logic [CNT_W-1:0]     sat_count
);

  // idx is one bit wider than out_idx so it can reach N_COLS ("all elements issued").
  localparam logic [IDX_W:0] CNT_END  = (IDX_W+1)'(N_COLS);
  localparam logic [IDX_W:0] LAST_IDX = (IDX_W+1)'(N_COLS - 1);

  drain_state_e            state, state_nxt;
  logic [N_COLS-1:0][15:0] row_buf;
  logic [IDX_W:0]          idx;
  logic [15:0]             cur;
  logic [7:0]              enc;
  logic                    enc_sat;
  logic                    slot_free;
  logic                    take_el;

  always_comb begin
    cur = '0;
    for (int i = 0; i < N_COLS; i++)
      if (idx == (IDX_W+1)'(i)) cur = row_buf[i];
  end

  bf16_to_fp8 u_enc (
    .bf16 (cur),
    .fp8  (enc),
    .sat  (enc_sat)
  );

  always_comb begin
    state_nxt  = state;
    load_ready = (state == IDLE);
    slot_free  = !out_valid || out_ready;
    take_el    = (state == DRAIN) && slot_free && (idx != CNT_END);
    case (state)
      IDLE:    if (load_valid) state_nxt = DRAIN;
      DRAIN:   if (idx == CNT_END) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      row_buf   <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      sat_count <= '0;
    end else begin
      state <= state_nxt;
      if (load_ready && load_valid) begin
        row_buf <= load_data;
        idx     <= '0;
      end
      if (take_el) begin
        out_valid <= 1'b1;
        out_data  <= enc;
        out_idx   <= idx[IDX_W-1:0];
        out_last  <= (idx == LAST_IDX);
        idx       <= idx + (IDX_W+1)'(1);
        if (enc_sat && sat_count != '1)
          sat_count <= sat_count + CNT_W'(1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
